// File: rtl/sparse_vec_pkg.sv
// Shared types and constants for the index-to-sparse-vector generator.
package sparse_vec_pkg;

    // Default parameter values for the LDGM signature path.
    localparam int N_DEF        = 9800;
    localparam int IDX_W_DEF    = 14;
    localparam int C_STRIDE_DEF = 50;
    localparam int M_STRIDE_DEF = 10;
    localparam int WGT_W_DEF    = 8;

    // Search controller states.
    typedef enum logic [2:0] {
        IDLE,
        COARSE,
        MID,
        FINE,
        COMMIT
    } state_t;

    // How the pointer and position move on the next edge.
    typedef enum logic [2:0] {
        HOLD,
        ADV_C,
        ADV_M,
        ADV_1,
        LOAD0
    } stride_sel_t;

    // Latency building blocks: every search stage ends with one
    // non-advancing cycle, commit takes one edge, a bad index takes one edge.
    localparam int LAT_STAGE_EXIT = 1;
    localparam int LAT_COMMIT     = 1;
    localparam int LAT_ERR        = 1;

endpackage

// File: rtl/sparse_onehot_shifter.sv
// One-hot pointer register that walks from bit 0 towards bit N-1 in
// coarse, mid or unit strides, and reports whether it hits a set bit.
module sparse_onehot_shifter
    import sparse_vec_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int C_STRIDE = C_STRIDE_DEF,
    parameter int M_STRIDE = M_STRIDE_DEF
) (
    input  logic         clk,
    input  logic         rst_b,
    input  stride_sel_t  sel,
    input  logic [0:N-1] vector,
    output logic [0:N-1] pointer,
    output logic         hit
);

    localparam logic [0:N-1] PTR_INIT = {1'b1, {(N-1){1'b0}}};

    // Pointer register: reload to bit 0 or shift towards higher indices.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pointer <= PTR_INIT;
        end else begin
            case (sel)
                LOAD0:   pointer <= PTR_INIT;
                ADV_C:   pointer <= pointer >> C_STRIDE;
                ADV_M:   pointer <= pointer >> M_STRIDE;
                ADV_1:   pointer <= pointer >> 1;
                default: pointer <= pointer;
            endcase
        end
    end

    assign hit = |(pointer & vector);

endmodule

// File: rtl/sparse_vec_gen.sv
// Converts a stream of column indices into an accumulated sparse vector.
// Each index is located by a coarse/mid/fine stride search of a one-hot
// pointer, which is then ORed into the accumulator. Also tracks weight,
// flags out-of-range indices and flags indices that are already set.
module sparse_vec_gen
    import sparse_vec_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int C_STRIDE = C_STRIDE_DEF,
    parameter int M_STRIDE = M_STRIDE_DEF,
    parameter int WGT_W    = WGT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] idx,
    input  logic             clr,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic             dup,
    output logic [WGT_W-1:0] weight,
    output logic [0:N-1]     vector
);

    // Position arithmetic is one bit wider than the index so pos + stride
    // can never wrap below the target.
    localparam int PW = IDX_W + 1;
    localparam logic [PW-1:0]    C_STEP  = PW'(C_STRIDE);
    localparam logic [PW-1:0]    M_STEP  = PW'(M_STRIDE);
    localparam logic [PW-1:0]    P_ONE   = PW'(1);
    localparam logic [PW-1:0]    N_EXT   = PW'(N);
    localparam logic [WGT_W-1:0] WGT_ONE = WGT_W'(1);

    state_t           state;
    state_t           state_nxt;
    stride_sel_t      sel;
    logic [IDX_W-1:0] idx_lat;
    logic [PW-1:0]    idx_ext;
    logic [PW-1:0]    pos;
    logic [PW-1:0]    c_next;
    logic [PW-1:0]    m_next;
    logic             c_adv;
    logic             m_adv;
    logic             f_adv;
    logic             bad_idx;
    logic             hit;
    logic [0:N-1]     pointer;

    assign idx_ext = {1'b0, idx_lat};
    assign c_next  = pos + C_STEP;
    assign m_next  = pos + M_STEP;
    assign c_adv   = (c_next <= idx_ext);
    assign m_adv   = (m_next <= idx_ext);
    assign f_adv   = (pos < idx_ext);
    assign bad_idx = ({1'b0, idx} >= N_EXT);

    sparse_onehot_shifter #(
        .N        (N),
        .C_STRIDE (C_STRIDE),
        .M_STRIDE (M_STRIDE)
    ) u_shifter (
        .clk     (clk),
        .rst_b   (rst_b),
        .sel     (sel),
        .vector  (vector),
        .pointer (pointer),
        .hit     (hit)
    );

    // State register; reset abandons any search in progress.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: each search stage exits on its first non-advancing cycle.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_idx) begin
                        state_nxt = COMMIT;
                    end else if (mode) begin
                        state_nxt = COARSE;
                    end else begin
                        state_nxt = MID;
                    end
                end
            end
            COARSE:  if (!c_adv) state_nxt = MID;
            MID:     if (!m_adv) state_nxt = FINE;
            FINE:    if (!f_adv) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: ready flag and the stride applied to pos and pointer.
    always_comb begin
        ready = (state == IDLE);
        sel   = HOLD;
        case (state)
            IDLE:    if (start) sel = LOAD0;
            COARSE:  if (c_adv) sel = ADV_C;
            MID:     if (m_adv) sel = ADV_M;
            FINE:    if (f_adv) sel = ADV_1;
            default: sel = HOLD;
        endcase
    end

    // Datapath: request latch, search position, accumulator and status flags.
    // NOTE: the accumulator is architectural state that must read as empty
    // after reset, so unlike a scratch memory it is reset explicitly.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idx_lat <= '0;
            pos     <= '0;
            vector  <= '0;
            weight  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            dup     <= 1'b0;
        end else begin
            done <= (state == COMMIT);

            case (sel)
                LOAD0:   pos <= '0;
                ADV_C:   pos <= c_next;
                ADV_M:   pos <= m_next;
                ADV_1:   pos <= pos + P_ONE;
                default: pos <= pos;
            endcase

            if (state == IDLE) begin
                if (clr) begin
                    vector <= '0;
                    weight <= '0;
                end
                if (start) begin
                    idx_lat <= idx;
                    err     <= bad_idx;
                    dup     <= 1'b0;
                end
            end

            if (state == COMMIT && !err) begin
                if (hit) begin
                    dup <= 1'b1;
                end else begin
                    vector <= vector | pointer;
                    if (weight != '1) begin
                        weight <= weight + WGT_ONE;
                    end
                end
            end
        end
    end

endmodule
